// File: rtl/ram_dp_init.sv
// Simple dual-port RAM with byte-enable writes, 1- or 2-cycle read latency,
// selectable read-during-write policy and a post-reset zero-fill sequencer.
module ram_dp_init #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_din,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_dout,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  req_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {INIT, READY} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              init_busy_q;
  logic              req_drop_q;
  logic [DATA_W-1:0] rd_dout_q;
  logic              rd_valid_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] wr_merged_d;
  logic [DATA_W-1:0] rd_word_d;
  logic              rd_en;

  assign rd_en = rst && (state_q == READY) && re;

  // The merged word doubles as the new-data read result, so both policies
  // resolve at the request edge regardless of output latency.
  always_comb begin
    wr_merged_d = mem[wr_addr];
    for (int unsigned i = 0; i < NB; i++) begin
      if (wr_be[i]) wr_merged_d[8*i +: 8] = wr_din[8*i +: 8];
    end
    rd_word_d = mem[rd_addr];
    if ((RDW_MODE == 1) && we && (wr_addr == rd_addr)) rd_word_d = wr_merged_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == INIT) mem[ptr_q] <= '0;
      else if (we)         mem[wr_addr] <= wr_merged_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      ptr_q       <= '0;
      init_busy_q <= 1'b1;
      req_drop_q  <= 1'b0;
    end else begin
      req_drop_q <= (state_q == INIT) && (we || re);
      if (state_q == INIT) begin
        ptr_q <= ptr_q + ADDR_W'(1);
        if (ptr_q == '1) begin
          state_q     <= READY;
          init_busy_q <= 1'b0;
        end
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s1_v_q;
      logic [DATA_W-1:0] s1_data_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          s1_v_q     <= 1'b0;
          s1_data_q  <= '0;
          rd_valid_q <= 1'b0;
          rd_dout_q  <= '0;
        end else begin
          s1_v_q     <= rd_en;
          if (rd_en) s1_data_q <= rd_word_d;
          rd_valid_q <= s1_v_q;
          if (s1_v_q) rd_dout_q <= s1_data_q;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_valid_q <= 1'b0;
          rd_dout_q  <= '0;
        end else begin
          rd_valid_q <= rd_en;
          if (rd_en) rd_dout_q <= rd_word_d;
        end
      end
    end
  endgenerate

  assign rd_dout   = rd_dout_q;
  assign rd_valid  = rd_valid_q;
  assign init_busy = init_busy_q;
  assign req_drop  = req_drop_q;

endmodule

// File: tb/tb_ram_dp_init.sv
// Bench for ram_dp_init: three 16-bit variants share one stimulus stream
// (old-data, new-data, 2-cycle latency) plus a 32-bit/64-deep variant.
module tb_ram_dp_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        we = 1'b0, re = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] wr_din = '0;

  logic        rst_d = 1'b0;
  logic        d_we = 1'b0, d_re = 1'b0;
  logic [5:0]  d_wa = '0, d_ra = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_din = '0;

  logic [15:0] a_dout, b_dout, c_dout;
  logic [31:0] d_dout;
  logic        a_vld, b_vld, c_vld, d_vld;
  logic        a_busy, b_busy, c_busy, d_busy;
  logic        a_drop, b_drop, c_drop, d_drop;

  ram_dp_init #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(a_dout), .rd_valid(a_vld),
    .init_busy(a_busy), .req_drop(a_drop));

  ram_dp_init #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(1)) u_b (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(b_dout), .rd_valid(b_vld),
    .init_busy(b_busy), .req_drop(b_drop));

  ram_dp_init #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(0)) u_c (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_be(wr_be), .wr_din(wr_din),
    .re(re), .rd_addr(rd_addr), .rd_dout(c_dout), .rd_valid(c_vld),
    .init_busy(c_busy), .req_drop(c_drop));

  ram_dp_init #(.DATA_W(32), .ADDR_W(6), .RD_LAT(1), .RDW_MODE(0)) u_d (
    .clk(clk), .rst(rst_d), .we(d_we), .wr_addr(d_wa), .wr_be(d_be), .wr_din(d_din),
    .re(d_re), .rd_addr(d_ra), .rd_dout(d_dout), .rd_valid(d_vld),
    .init_busy(d_busy), .req_drop(d_drop));

  logic        vld  [4];
  logic [31:0] dout [4];
  assign vld[0] = a_vld;  assign dout[0] = {16'h0, a_dout};
  assign vld[1] = b_vld;  assign dout[1] = {16'h0, b_dout};
  assign vld[2] = c_vld;  assign dout[2] = {16'h0, c_dout};
  assign vld[3] = d_vld;  assign dout[3] = d_dout;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t q [4][$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard: each expected read carries the cycle in which rd_valid must show.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int d = 0; d < 4; d++) begin
      logic exp_v;
      exp_v = (q[d].size() != 0) && (q[d][0].cyc == cyc);
      if (vld[d] || exp_v) begin
        chk($sformatf("rd_valid[%0d]", d), {31'h0, vld[d]}, {31'h0, exp_v});
        if (exp_v) begin
          if (vld[d]) chk($sformatf("rd_dout[%0d]", d), dout[d], q[d][0].data);
          void'(q[d].pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_rd(input logic [15:0] e0, input logic [15:0] e1);
    exp_t e;
    e.cyc = cyc + 1; e.data = {16'h0, e0}; q[0].push_back(e);
    e.data = {16'h0, e1};                  q[1].push_back(e);
    e.cyc = cyc + 2; e.data = {16'h0, e0}; q[2].push_back(e);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) q[d].delete();
    repeat (n) tick();
    rst = 1'b1;
  endtask

  function automatic logic busy_of(input int which);
    return (which == 0) ? a_busy : d_busy;
  endfunction

  task automatic count_init(input int which, input int exp, input string name);
    int n = 0;
    while (busy_of(which) && n < 200) begin
      n++;
      tick();
    end
    chk(name, n, exp);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [1:0]  be;
    logic [15:0] din;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 4'd5, 2'b11, 16'hABCD, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 4'd5, 2'b01, 16'h1234, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd5, 16'hAB34, 16'hAB34};
    tbl[3]  = '{1'b1, 4'd5, 2'b00, 16'hFFFF, 1'b1, 4'd5, 16'hAB34, 16'hAB34};
    tbl[4]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd5, 16'hAB34, 16'hAB34};
    tbl[5]  = '{1'b1, 4'd3, 2'b11, 16'h1111, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 4'd3, 2'b10, 16'h2222, 1'b1, 4'd3, 16'h1111, 16'h2211};
    tbl[7]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd3, 16'h2211, 16'h2211};
    tbl[8]  = '{1'b1, 4'd7, 2'b11, 16'h7777, 1'b1, 4'd3, 16'h2211, 16'h2211};
    tbl[9]  = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd7, 16'h7777, 16'h7777};
    tbl[10] = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'd15, 16'h0000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      tbl[11+i] = '{1'b1, 4'(i), 2'b11, 16'h00A0 + 16'(i), 1'b0, 4'd0, 16'h0000, 16'h0000};
      tbl[15+i] = '{1'b0, 4'd0, 2'b00, 16'h0000, 1'b1, 4'(i), 16'h00A0 + 16'(i), 16'h00A0 + 16'(i)};
    end

    // Reset held 3 edges with requests active: no drop pulse, outputs cleared.
    we = 1'b1; re = 1'b1; wr_addr = 4'd0; wr_be = 2'b11; wr_din = 16'hFFFF;
    repeat (3) tick();
    chk("reset req_drop", {31'h0, a_drop}, 32'h0);
    chk("reset init_busy", {31'h0, a_busy}, 32'h1);
    chk("reset rd_valid", {31'h0, a_vld}, 32'h0);
    chk("reset rd_dout", {16'h0, c_dout}, 32'h0);
    rst = 1'b1;

    // Init: busy for 16 cycles, every sampled request dropped.
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("init_busy E%0d", k), {29'h0, a_busy, b_busy, c_busy},
          (k < 15) ? 32'h7 : 32'h0);
      chk($sformatf("req_drop E%0d", k), {29'h0, a_drop, b_drop, c_drop}, 32'h7);
    end

    // First accepted request at E16; dropped writes must not have landed.
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      push_rd(16'h0000, 16'h0000);
      tick();
      if (i == 0) chk("req_drop after init", {31'h0, a_drop}, 32'h0);
    end
    re = 1'b0;

    for (int i = 0; i < 19; i++) begin
      we = tbl[i].we; wr_addr = tbl[i].wa; wr_be = tbl[i].be; wr_din = tbl[i].din;
      re = tbl[i].re; rd_addr = tbl[i].ra;
      if (tbl[i].re) push_rd(tbl[i].exp0, tbl[i].exp1);
      tick();
    end
    we = 1'b0; re = 1'b0;
    repeat (3) tick();
    chk("rd_dout hold lat1", {16'h0, a_dout}, 32'h00A3);
    chk("rd_dout hold lat2", {16'h0, c_dout}, 32'h00A3);

    // Reset one edge after a RD_LAT=2 read was issued: its valid is lost.
    re = 1'b1; rd_addr = 4'd0;
    begin
      exp_t e;
      e.cyc = cyc + 1; e.data = 32'h00A0;
      q[0].push_back(e);
      q[1].push_back(e);
    end
    tick();
    re = 1'b0;
    do_reset(1);
    chk("flushed rd_valid", {31'h0, c_vld}, 32'h0);
    chk("flushed rd_dout", {16'h0, c_dout}, 32'h0);
    repeat (7) tick();
    chk("mid-init busy", {31'h0, a_busy}, 32'h1);
    do_reset(1);
    count_init(0, 16, "re-init busy cycles");

    re = 1'b1;
    rd_addr = 4'd7; push_rd(16'h0000, 16'h0000); tick();
    rd_addr = 4'd5; push_rd(16'h0000, 16'h0000); tick();
    re = 1'b0;
    repeat (3) tick();

    // Wide/deep variant.
    tick();
    rst_d = 1'b1;
    count_init(1, 64, "wide init_busy cycles");
    d_we = 1'b1; d_wa = 6'd63; d_be = 4'hF; d_din = 32'hDEADBEEF;
    tick();
    d_we = 1'b0; d_re = 1'b1; d_ra = 6'd63;
    begin
      exp_t e;
      e.cyc = cyc + 1; e.data = 32'hDEADBEEF; q[3].push_back(e);
      tick();
      d_re = 1'b0; d_we = 1'b1; d_be = 4'b0101; d_din = 32'h11223344;
      tick();
      d_we = 1'b0; d_re = 1'b1;
      e.cyc = cyc + 1; e.data = 32'hDE22BE44; q[3].push_back(e);
      tick();
      d_ra = 6'd62;
      e.cyc = cyc + 1; e.data = 32'h0; q[3].push_back(e);
      tick();
    end
    d_re = 1'b0;
    repeat (3) tick();
    chk("wide req_drop", {31'h0, d_drop}, 32'h0);
    chk("scoreboard drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
